// File: rtl/pulse_arb_pkg.sv
// Shared types and helpers for the pulse-BRAM round-robin arbiter.
//   arb_state_t : arbiter FSM states (IDLE, ARB, BUSY, GAP)
//   MAX_REQ     : largest supported requester count
//   IDX_MAX_W   : index width for MAX_REQ requesters
//   onehot()    : index -> one-hot vector of MAX_REQ bits
package pulse_arb_pkg;

  localparam int unsigned MAX_REQ   = 8;
  localparam int unsigned IDX_MAX_W = $clog2(MAX_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    BUSY = 2'd2,
    GAP  = 2'd3
  } arb_state_t;

  function automatic logic [MAX_REQ-1:0] onehot(input logic [IDX_MAX_W-1:0] idx);
    logic [MAX_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/pulse_bram_arbiter_if.sv
// Bus bundle between the pulse generators, the arbiter and the pulse BRAM.
//   req/req_addr/req_din/req_we/req_en : per-requester request side (flattened)
//   gnt                                : one-hot grant back to the requesters
//   bram_addr/bram_din/bram_we/bram_en : muxed single BRAM port
// Modports: master = generator side, slave = arbiter, mem = BRAM side.
interface pulse_bram_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_din;
  logic [NUM_REQ-1:0]    req_we;
  logic [NUM_REQ-1:0]    req_en;
  logic [NUM_REQ-1:0]    gnt;
  logic [AW-1:0]         bram_addr;
  logic [DW-1:0]         bram_din;
  logic                  bram_we;
  logic                  bram_en;

  modport master (
    output req, req_addr, req_din, req_we, req_en,
    input  gnt
  );

  modport slave (
    input  req, req_addr, req_din, req_we, req_en,
    output gnt, bram_addr, bram_din, bram_we, bram_en
  );

  modport mem (
    input bram_addr, bram_din, bram_we, bram_en
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
//   i_req   : request vector
//   i_mask  : requesters excluded from this pick
//   i_ptr   : index where the search starts (wraps NUM_REQ-1 -> 0)
//   o_idx   : first eligible requester at or after i_ptr
//   o_valid : any eligible requester present
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [NUM_REQ-1:0]         i_mask,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  output logic [$clog2(NUM_REQ)-1:0] o_idx,
  output logic                       o_valid
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] w_eligible;
  int unsigned        w_j;

  always_comb begin
    w_eligible = i_req & ~i_mask;
    o_idx      = '0;
    o_valid    = 1'b0;
    w_j        = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_j = (32'(i_ptr) + k) % NUM_REQ;
      if (!o_valid && w_eligible[w_j]) begin
        o_idx   = IDX_W'(w_j);
        o_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/pulse_bram_arbiter.sv
// Round-robin arbiter sharing one pulse-BRAM port among NUM_REQ pulse
// generators. A requester holds the port for a whole burst (req high) and
// releases it by dropping req; one dead GAP cycle follows every burst.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pulse_bram_arbiter_if.slave (requests in, grant + BRAM port out)
//   busy       : a grant is active
//   owner      : index of the current or last owner
//   timeout    : 1-cycle pulse when a burst is forcibly revoked
// Optional feature: define PULSE_ARB_TIMEOUT_EN to limit bursts to MAX_HOLD
// BUSY cycles; the revoked requester is masked until its req goes low.
module pulse_bram_arbiter
  import pulse_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_HOLD = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  pulse_bram_arbiter_if.slave        bus,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       timeout
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  arb_state_t         r_state;
  arb_state_t         w_next;
  logic [IDX_W-1:0]   r_owner;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   w_pick_idx;
  logic [IDX_W-1:0]   w_ptr_next;
  logic               w_pick_valid;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] w_mask;
  logic [NUM_REQ-1:0] w_owner_oh;
  logic               r_busy;
  logic               w_owner_req;
  logic               w_release;
  logic               w_expire;

  assign w_owner_oh  = NUM_REQ'(onehot(IDX_MAX_W'(r_owner)));
  assign w_ptr_next  = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);
  assign w_owner_req = bus.req[r_owner];
  assign w_release   = (r_state == BUSY) && !w_owner_req;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .i_req   (bus.req),
    .i_mask  (w_mask),
    .i_ptr   (r_ptr),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

`ifdef PULSE_ARB_TIMEOUT_EN
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD) + 1;

  logic [HOLD_W-1:0]  r_hold;
  logic [NUM_REQ-1:0] r_mask;
  logic               r_timeout;

  // A voluntary release in the same cycle wins over the limit.
  assign w_expire = (r_state == BUSY) && w_owner_req &&
                    (r_hold == HOLD_W'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold    <= '0;
      r_mask    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_expire;
      // A revoked requester stays masked until it drops its req.
      r_mask    <= (r_mask & bus.req) | (w_expire ? w_owner_oh : '0);
      if (r_state == ARB) begin
        r_hold <= '0;
      end else if (r_state == BUSY) begin
        r_hold <= r_hold + HOLD_W'(1);
      end
    end
  end

  assign w_mask  = r_mask;
  assign timeout = r_timeout;
`else
  assign w_expire = 1'b0;
  assign w_mask   = '0;
  assign timeout  = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_pick_valid) w_next = ARB;
      ARB:     w_next = BUSY;
      BUSY:    if (w_release || w_expire) w_next = GAP;
      GAP:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Registered grant, owner and pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= '0;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_pick_valid) r_owner <= w_pick_idx;
        ARB: begin
          r_gnt  <= w_owner_oh;
          r_busy <= 1'b1;
        end
        BUSY: if (w_release || w_expire) begin
          r_gnt  <= '0;
          r_busy <= 1'b0;
          r_ptr  <= w_ptr_next;
        end
        default: ;
      endcase
    end
  end

  // BRAM port mux; strobes only pass while BUSY, so they drop with reset.
  always_comb begin
    bus.bram_addr = bus.req_addr[32'(r_owner) * AW +: AW];
    bus.bram_din  = bus.req_din[32'(r_owner) * DW +: DW];
    bus.bram_en   = 1'b0;
    bus.bram_we   = 1'b0;
    if (r_state == BUSY) begin
      bus.bram_en = bus.req_en[r_owner];
      bus.bram_we = bus.req_we[r_owner];
    end
  end

  assign bus.gnt = r_gnt;
  assign busy    = r_busy;
  assign owner   = r_owner;
endmodule

// File: tb/tb_pulse_bram_arbiter.sv
module tb_pulse_bram_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MH = 16;
`ifdef PULSE_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]  t_req = '0;
  logic [N-1:0]  t_we  = '0;
  logic [N-1:0]  t_en  = '0;
  logic [AW-1:0] t_addr [N];
  logic [DW-1:0] t_din  [N];

  logic       busy;
  logic [1:0] owner;
  logic       timeout;

  pulse_bram_arbiter_if #(.NUM_REQ(N), .AW(AW), .DW(DW)) bus ();

  always_comb begin
    bus.req      = t_req;
    bus.req_we   = t_we;
    bus.req_en   = t_en;
    bus.req_addr = '0;
    bus.req_din  = '0;
    for (int i = 0; i < N; i++) begin
      bus.req_addr[i*AW +: AW] = t_addr[i];
      bus.req_din[i*DW +: DW]  = t_din[i];
    end
  end

  pulse_bram_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW), .MAX_HOLD(MH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .busy    (busy),
    .owner   (owner),
    .timeout (timeout)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 grant pending, 2 holding the port, 3 dead cycle
  int           m_phase = 0;
  int           m_owner = 0;
  int           m_ptr   = 0;
  int           m_busy_cycles = 0;
  logic [N-1:0] m_mask  = '0;
  logic [N-1:0] m_set;
  bit           m_to    = 1'b0;
  int           m_p;

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_phase = 0; m_owner = 0; m_ptr = 0; m_busy_cycles = 0;
      m_mask = '0; m_to = 1'b0;
    end else begin
      m_to  = 1'b0;
      m_set = '0;
      case (m_phase)
        0: begin
          m_p = pick(t_req & ~m_mask, m_ptr);
          if (m_p >= 0) begin m_owner = m_p; m_phase = 1; end
        end
        1: begin m_phase = 2; m_busy_cycles = 1; end
        2: begin
          if (!t_req[m_owner]) begin
            m_phase = 3; m_ptr = (m_owner + 1) % N;
          end else if (TO_EN && m_busy_cycles == MH) begin
            m_phase = 3; m_ptr = (m_owner + 1) % N;
            m_to = 1'b1; m_set[m_owner] = 1'b1;
          end else begin
            m_busy_cycles++;
          end
        end
        default: m_phase = 0;
      endcase
      m_mask = (m_mask & t_req) | m_set;
    end
  end

  // ---------------- compare process + grant log ----------------
  logic [N-1:0] e_gnt;
  logic [N-1:0] prev_gnt = '0;
  int           glog[$];

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      e_gnt = '0;
      if (m_phase == 2) e_gnt[m_owner] = 1'b1;
      chk("gnt",     bus.gnt,     e_gnt);
      chk("busy",    busy,        m_phase == 2);
      chk("owner",   owner,       m_owner);
      chk("bram_en", bus.bram_en, (m_phase == 2) && t_en[m_owner]);
      chk("bram_we", bus.bram_we, (m_phase == 2) && t_we[m_owner]);
      chk("timeout", timeout,     m_to);
      if (m_phase == 2) begin
        chk("bram_addr", bus.bram_addr, t_addr[m_owner]);
        chk("bram_din",  bus.bram_din,  t_din[m_owner]);
      end
      if (bus.gnt != '0 && prev_gnt == '0) begin
        for (int i = 0; i < N; i++) if (bus.gnt[i]) glog.push_back(i);
      end
    end
    prev_gnt = bus.gnt;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_gnt(output int idx);
    idx = -1;
    for (int c = 0; c < 20; c++) begin
      if (bus.gnt != '0) begin
        for (int i = 0; i < N; i++) if (bus.gnt[i]) idx = i;
        return;
      end
      tick(1);
    end
    n_cmp++;
    n_bad++;
    $display("FAIL wait_gnt: no grant within 20 cycles, expected a grant");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    t_req = '0; t_we = '0; t_en = '0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    glog.delete();
  endtask

  task automatic chk_order(input string nm, input int exp_q[$]);
    chk({nm, "_len"}, glog.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk(nm, (i < glog.size()) ? glog[i] : -1, exp_q[i]);
  endtask

  int w;
  int g_cnt, t_cnt;

  initial begin
    for (int i = 0; i < N; i++) begin
      t_addr[i] = 32'h0000_1000 + 32'(i) * 32'h100;
      t_din[i]  = 32'h3F80_0000 + 32'(i);
    end
    // Reset state, sampled with rst_n held low
    #1;
    chk("rst_gnt", bus.gnt, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_owner", owner, 2'd0);
    chk("rst_en", bus.bram_en, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    do_reset();

    // 1: single requester, grant latency and release
    t_en[0] = 1'b1; t_we[0] = 1'b1; t_req[0] = 1'b1;
    tick(1);
    chk("t1_gnt_arb", bus.gnt, 4'b0000);
    tick(1);
    chk("t1_gnt", bus.gnt, 4'b0001);
    chk("t1_en", bus.bram_en, 1'b1);
    t_en[0] = 1'b0;
    tick(1);
    chk("t1_en_follow", bus.bram_en, 1'b0);
    t_en[0] = 1'b1;
    tick(2);
    t_req[0] = 1'b0;
    tick(1);
    chk("t1_gnt_rel", bus.gnt, 4'b0000);
    chk("t1_gap_en", bus.bram_en, 1'b0);
    tick(2);

    // 2: all request, round robin 0,1,2,3,0
    do_reset();
    t_req = 4'b1111; t_en = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(w);
      if (w < 0) break;
      tick(5);
      t_req[w] = 1'b0;
      tick(1);
      t_req[w] = 1'b1;
    end
    t_req = '0;
    tick(4);
    chk_order("t2_order", '{0, 1, 2, 3, 0});

    // 3: late arrivals during req1's burst -> 2 then 0
    do_reset();
    t_en = 4'b0111;
    t_req = 4'b0010;
    wait_gnt(w);
    tick(2);
    t_req = t_req | 4'b0101;
    tick(3);
    t_req[1] = 1'b0;
    tick(1);
    wait_gnt(w);
    chk("t3_second", w, 2);
    tick(3);
    t_req[2] = 1'b0;
    tick(1);
    wait_gnt(w);
    chk("t3_third", w, 0);
    tick(2);
    t_req[0] = 1'b0;
    tick(3);
    chk_order("t3_order", '{1, 2, 0});

    // 5: non-owner strobes never reach the BRAM
    do_reset();
    t_req = 4'b0001; t_en = 4'b0001; t_we = 4'b0001;
    wait_gnt(w);
    t_req = 4'b0011; t_en = 4'b0011; t_we = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      t_addr[0] = 32'h0000_2000 + 32'(i) * 4;
      t_addr[1] = 32'h0000_9000 + 32'(i) * 4;
      tick(1);
      chk("t5_addr", bus.bram_addr, 32'h0000_2000 + 32'(i) * 4);
    end
    t_we[0] = 1'b0;
    tick(1);
    chk("t5_we_owner_only", bus.bram_we, 1'b0);
    t_req[0] = 1'b0;
    tick(1);
    wait_gnt(w);
    chk("t5_next_owner", w, 1);
    chk("t5_addr1", bus.bram_addr, 32'h0000_900C);
    t_req = '0;
    tick(3);

    // 4: async reset mid-burst, pointer returns to 0
    do_reset();
    t_req = 4'b0001;
    wait_gnt(w);
    tick(1);
    t_req = '0;
    tick(2);
    t_req = 4'b0100; t_en = 4'b0100; t_we = 4'b0100;
    wait_gnt(w);
    tick(1);
    chk("t4_we_before", bus.bram_we, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t4_we_async", bus.bram_we, 1'b0);
    chk("t4_en_async", bus.bram_en, 1'b0);
    chk("t4_gnt_async", bus.gnt, 4'b0000);
    chk("t4_busy_async", busy, 1'b0);
    t_req = 4'b1001; t_en = '0; t_we = '0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    wait_gnt(w);
    chk("t4_first_after_rst", w, 0);
    t_req = '0;
    tick(3);

    // 6: long burst, revoked only with the timeout feature
    do_reset();
    t_req = 4'b0001; t_en = 4'b0001;
    wait_gnt(w);
    g_cnt = 1;
    t_cnt = 0;
    for (int i = 0; i < 39; i++) begin
      tick(1);
      if (bus.gnt[0]) g_cnt++;
      if (timeout) t_cnt++;
    end
    chk("t6_gnt_cycles", g_cnt, TO_EN ? 16 : 40);
    chk("t6_timeout_pulses", t_cnt, TO_EN ? 1 : 0);
    t_req = '0;
    tick(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
